// File: rtl/fifo_word_packer_pkg.sv
// Shared definitions for the FIFO word packer: state encoding, default
// widths and the keep-mask helper used when a partial word is emitted.
package fifo_pack_pkg;

    localparam int BYTE_W                 = 8;
    localparam int DEFAULT_BYTES_PER_WORD = 4;

    localparam logic STATE_FILL = 1'b0;
    localparam logic STATE_HOLD = 1'b1;

    // Thermometer mask with the low n bits set; n = 8 yields all ones.
    function automatic logic [7:0] thermoMask(input logic [3:0] n);
        thermoMask = (8'h01 << n) - 8'h01;
    endfunction

endpackage

// File: rtl/fifo_word_packer_idle_timer.sv
// Idle down-counter for the word packer. Reloads on clear, counts down
// while enabled and signals expiry on the TIMEOUT_CYCLES-th idle cycle.
module pack_idle_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [7:0] RELOAD = 8'(TIMEOUT_CYCLES);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: reload on clear, step down while idle, stop at one.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = RELOAD;
        end else if (enable_i && (count_q > 8'd1)) begin
            count_d = count_q - 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i & (count_q == 8'd1);

endmodule

// File: rtl/fifo_word_packer.sv
// Drains bytes from a show-ahead FIFO and packs them little-endian into
// words on a valid/ready master port, with flush-driven partial words.
// Optional build macro PACK_TIMEOUT_EN adds an idle-timeout auto flush.
module fifo_word_packer
    import fifo_pack_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEFAULT_BYTES_PER_WORD,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             fifo_empty,
    input  logic [7:0]                       fifo_data,
    output logic                             fifo_read,
    input  logic                             flush,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [BYTE_W*BYTES_PER_WORD-1:0] m_data,
    output logic [BYTES_PER_WORD-1:0]        m_keep
);

    localparam int CNT_W  = $clog2(BYTES_PER_WORD + 1);
    localparam int DATA_W = BYTE_W * BYTES_PER_WORD;

    logic              state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BYTES_PER_WORD-1:0] keep_q, keep_d;

    logic              pop;
    logic              flushReq;
    logic              timeoutFlush;
    logic [CNT_W-1:0]  cntInc;
    logic [7:0]        keepMaskAll;

    // Pop whenever a byte is available and there is room: always in FILL,
    // and in HOLD only on the handshake edge so the next word starts at once.
    assign fifo_read = rst_n & ~fifo_empty & ((state_q == STATE_FILL) | m_ready);
    assign pop       = fifo_read;

    assign cntInc      = cnt_q + {{(CNT_W-1){1'b0}}, pop};
    assign keepMaskAll = thermoMask(4'(cntInc));
    assign flushReq    = flush | timeoutFlush;

`ifdef PACK_TIMEOUT_EN
    logic timerClear;
    assign timerClear = pop | (state_q != STATE_FILL) | (cnt_q == '0);

    pack_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (timerClear),
        .enable_i (~timerClear),
        .expire_o (timeoutFlush)
    );
`else
    // No timer in this build; the comparison is false for every legal value.
    assign timeoutFlush = (TIMEOUT_CYCLES < 0);
`endif

    // Word assembly and FILL/HOLD sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        keep_d  = keep_q;
        if (state_q == STATE_FILL) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (pop && (cnt_q == CNT_W'(i))) begin
                    data_d[i*BYTE_W +: BYTE_W] = fifo_data;
                end
            end
            if (cntInc == CNT_W'(BYTES_PER_WORD)) begin
                state_d = STATE_HOLD;
                keep_d  = '1;
                cnt_d   = '0;
            end else if (flushReq && (cntInc != '0)) begin
                state_d = STATE_HOLD;
                keep_d  = keepMaskAll[BYTES_PER_WORD-1:0];
                cnt_d   = '0;
            end else begin
                cnt_d = cntInc;
            end
        end else if (m_ready) begin
            state_d = STATE_FILL;
            keep_d  = '0;
            data_d  = '0;
            if (pop) begin
                data_d[BYTE_W-1:0] = fifo_data;
                cnt_d              = CNT_W'(1);
            end else begin
                cnt_d = '0;
            end
        end
    end

    // State registers; reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
        end
    end

    assign m_valid = (state_q == STATE_HOLD);
    assign m_data  = data_q;
    assign m_keep  = keep_q;

endmodule
